chad_bank_stack: RTL and testbench

Parametrised, banked LIFO stack for the chad core family: CONTEXTS independent stacks of DEPTH cells each, sharing one storage array and one access port, selected per cycle by a context index. It replaces the single-context data/return stack in multi-task chad builds, so a task switch needs only a new `ctx` value, with no spill or fill. It adds per-context depth tracking and sticky overflow/underflow flags for stack-fault exceptions.

---
 rtl/chad_pkg.sv | 24 ++
 rtl/chad_stack_ptr.sv | 90 +++++++++
 rtl/chad_bank_stack.sv | 99 +++++++++
 tb/tb_chad_bank_stack.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/chad_pkg.sv
// chad_pkg: shared constants and width helpers for the banked chad stack.
//   D_NONE/D_PUSH/D_POP/D_POP2 : two's-complement pointer step encodings
//   sp_w/dc_w/ctx_w            : widths of pointer, depth count and context index
package chad_pkg;

  localparam logic [1:0] D_NONE = 2'b00;
  localparam logic [1:0] D_PUSH = 2'b01;
  localparam logic [1:0] D_POP  = 2'b11;
  localparam logic [1:0] D_POP2 = 2'b10;

  function automatic int sp_w(input int depth);
    return $clog2(depth);
  endfunction

  // Depth count must represent 0..DEPTH inclusive.
  function automatic int dc_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ctx_w(input int contexts);
    return (contexts > 1) ? $clog2(contexts) : 1;
  endfunction

endpackage

// File: rtl/chad_stack_ptr.sv
// chad_stack_ptr: pointer / depth / sticky-flag tracker for one stack context.
// Optional guard logic (depth count, ovf/unf, clr_err) under CHAD_STACK_GUARD_EN.
//   clk, resetq : clock, async active-low reset
//   en          : this context is selected and not held
//   delta       : pointer step (D_NONE/D_PUSH/D_POP/D_POP2)
//   clr_err     : clear sticky flags (an error in the same cycle wins)
//   sp, sp_nxt  : current pointer and pointer after this cycle's step
//   dc          : occupancy 0..DEPTH (0 without guard)
//   ovf, unf    : sticky overflow / underflow (0 without guard)
module chad_stack_ptr
  import chad_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetq,
  input  logic                     en,
  input  logic [1:0]               delta,
  input  logic                     clr_err,
  output logic [sp_w(DEPTH)-1:0]   sp,
  output logic [sp_w(DEPTH)-1:0]   sp_nxt,
  output logic [dc_w(DEPTH)-1:0]   dc,
  output logic                     ovf,
  output logic                     unf
);

  localparam int SPW = sp_w(DEPTH);
  localparam int DCW = dc_w(DEPTH);

  logic [SPW-1:0] step;

  // Sign-extend delta; wraparound modulo DEPTH falls out of the pointer width.
  assign step   = SPW'($signed(delta));
  assign sp_nxt = sp + step;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)  sp <= '0;
    else if (en)  sp <= sp_nxt;
  end

`ifdef CHAD_STACK_GUARD_EN
  logic [DCW-1:0] dc_nxt;
  logic           ovf_evt, unf_evt;

  always_comb begin
    dc_nxt  = dc;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    case (delta)
      D_PUSH: begin
        // Full stack wraps over its oldest cell; count saturates.
        if (dc == DCW'(DEPTH)) ovf_evt = 1'b1;
        else                   dc_nxt  = dc + DCW'(1);
      end
      D_POP: begin
        if (dc == '0) unf_evt = 1'b1;
        else          dc_nxt  = dc - DCW'(1);
      end
      D_POP2: begin
        if (dc < DCW'(2)) begin
          unf_evt = 1'b1;
          dc_nxt  = '0;
        end else begin
          dc_nxt  = dc - DCW'(2);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      dc  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (en) begin
      dc  <= dc_nxt;
      ovf <= (ovf & ~clr_err) | ovf_evt;
      unf <= (unf & ~clr_err) | unf_evt;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_err;
  assign dc  = '0;
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: rtl/chad_bank_stack.sv
// chad_bank_stack: CONTEXTS banked LIFO stacks of DEPTH cells sharing one
// storage array and one access port, selected per cycle by ctx.
// Build option CHAD_STACK_GUARD_EN: adds depth count, sticky ovf/unf, fault,
// clr_err, and clears storage on reset. Without it those outputs are 0.
//   clk, resetq : clock, async active-low reset
//   hold        : freeze all updates
//   ctx         : context select (combinational for rd/depth/ovf/unf)
//   delta, we, wd : pointer step, write enable, write data (lands at new top)
//   rd, depth   : top cell and occupancy of selected context
//   clr_err     : clear selected context's sticky flags
//   ovf, unf    : sticky flags of selected context
//   fault       : registered OR of all contexts' flags
module chad_bank_stack
  import chad_pkg::*;
#(
  parameter int WIDTH    = 18,
  parameter int DEPTH    = 16,
  parameter int CONTEXTS = 4
) (
  input  logic                        clk,
  input  logic                        resetq,
  input  logic                        hold,
  input  logic [ctx_w(CONTEXTS)-1:0]  ctx,
  input  logic [1:0]                  delta,
  input  logic                        we,
  input  logic [WIDTH-1:0]            wd,
  output logic [WIDTH-1:0]            rd,
  output logic [dc_w(DEPTH)-1:0]      depth,
  input  logic                        clr_err,
  output logic                        ovf,
  output logic                        unf,
  output logic                        fault
);

  localparam int SPW = sp_w(DEPTH);
  localparam int DCW = dc_w(DEPTH);
  localparam int CW  = ctx_w(CONTEXTS);
  localparam int AW  = $clog2(CONTEXTS) + SPW;
  localparam int NC  = CONTEXTS * DEPTH;

  logic [CW-1:0]                 cs;
  logic [CONTEXTS-1:0]           en;
  logic [CONTEXTS-1:0][SPW-1:0]  sp_q, sp_n;
  logic [CONTEXTS-1:0][DCW-1:0]  dc_q;
  logic [CONTEXTS-1:0]           ovf_q, unf_q;
  logic [AW-1:0]                 wa, ra;
  logic [WIDTH-1:0]              mem [NC];

  // A single-context build has a 1-bit ctx port that selects nothing.
  assign cs = (CONTEXTS > 1) ? ctx : '0;

  for (genvar c = 0; c < CONTEXTS; c++) begin : g_ctx
    assign en[c] = ~hold & (cs == CW'(c));
    chad_stack_ptr #(.DEPTH(DEPTH)) u_ptr (
      .clk     (clk),
      .resetq  (resetq),
      .en      (en[c]),
      .delta   (delta),
      .clr_err (clr_err),
      .sp      (sp_q[c]),
      .sp_nxt  (sp_n[c]),
      .dc      (dc_q[c]),
      .ovf     (ovf_q[c]),
      .unf     (unf_q[c])
    );
  end

  // Truncating the cast drops the dummy ctx bit when CONTEXTS == 1.
  assign wa = AW'({cs, sp_n[cs]});
  assign ra = AW'({cs, sp_q[cs]});

  assign rd    = mem[ra];
  assign depth = dc_q[cs];
  assign ovf   = ovf_q[cs];
  assign unf   = unf_q[cs];

`ifdef CHAD_STACK_GUARD_EN
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      for (int i = 0; i < NC; i++) mem[i] <= '0;
    end else if (!hold && we) begin
      mem[wa] <= wd;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) fault <= 1'b0;
    else         fault <= (|ovf_q) | (|unf_q);
  end
`else
  // resetq gates the write so an edge during reset never commits data.
  always_ff @(posedge clk) begin
    if (resetq && !hold && we) mem[wa] <= wd;
  end

  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_chad_bank_stack.sv
module tb_chad_bank_stack;

`ifdef CHAD_STACK_GUARD_EN
  localparam bit G = 1'b1;
`else
  localparam bit G = 1'b0;
`endif

  localparam logic [1:0] NONE = 2'b00, PUSH = 2'b01, POP = 2'b11, POP2 = 2'b10;

  logic        clk = 1'b0, resetq = 1'b0, hold = 1'b0, we = 1'b0, clr_err = 1'b0;
  logic [1:0]  ctx = '0, delta = '0;
  logic [17:0] wd = '0, rd;
  logic [4:0]  depth;
  logic        ovf, unf, fault;

  chad_bank_stack #(.WIDTH(18), .DEPTH(16), .CONTEXTS(4)) dut (
    .clk(clk), .resetq(resetq), .hold(hold), .ctx(ctx), .delta(delta),
    .we(we), .wd(wd), .rd(rd), .depth(depth), .clr_err(clr_err),
    .ovf(ovf), .unf(unf), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // reference state
  int          msp [4], mdc [4];
  bit          movf [4], munf [4];
  logic [17:0] mmem [4][16];
  bit          mval [4][16];

  typedef struct {
    string       tag;
    logic [17:0] rd;
    bit          rdv;
    int          dep;
    bit          ovf, unf, fault;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int sx(input logic [1:0] d);
    case (d)
      PUSH:    return 1;
      POP:     return -1;
      POP2:    return -2;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      msp[c] = 0; mdc[c] = 0; movf[c] = 0; munf[c] = 0;
      if (G) for (int i = 0; i < 16; i++) begin mmem[c][i] = '0; mval[c][i] = 1; end
    end
  endtask

  function automatic exp_t peek(input string tag, input int c, input bit flt);
    exp_t e;
    e.tag = tag; e.rd = mmem[c][msp[c]]; e.rdv = mval[c][msp[c]];
    e.dep = G ? mdc[c] : 0; e.ovf = G && movf[c]; e.unf = G && munf[c];
    e.fault = flt;
    return e;
  endfunction

  task automatic compare_top();
    exp_t e;
    e = sb.pop_front();
    if (e.rdv) chk({e.tag, ".rd"}, 32'(rd), 32'(e.rd));
    chk({e.tag, ".depth"}, 32'(depth), 32'(e.dep));
    chk({e.tag, ".ovf"},   32'(ovf),   32'(e.ovf));
    chk({e.tag, ".unf"},   32'(unf),   32'(e.unf));
    chk({e.tag, ".fault"}, 32'(fault), 32'(e.fault));
  endtask

  // One operation: drive at negedge, predict, compare just after the edge.
  task automatic op(input string tag, input int c, input logic [1:0] d, input bit w,
                    input logic [17:0] data, input bit h, input bit clr);
    bit orold, oe, ue;
    int nsp;
    @(negedge clk);
    ctx = 2'(c); delta = d; we = w; wd = data; hold = h; clr_err = clr;
    orold = 0;
    for (int k = 0; k < 4; k++) orold |= movf[k] | munf[k];
    orold &= G;
    if (!h) begin
      nsp = (msp[c] + sx(d)) & 15;
      oe = 0; ue = 0;
      if (G) begin
        case (d)
          PUSH: if (mdc[c] == 16) oe = 1; else mdc[c]++;
          POP:  if (mdc[c] < 1) begin ue = 1; mdc[c] = 0; end else mdc[c]--;
          POP2: if (mdc[c] < 2) begin ue = 1; mdc[c] = 0; end else mdc[c] -= 2;
          default: ;
        endcase
        movf[c] = (movf[c] && !clr) || oe;
        munf[c] = (munf[c] && !clr) || ue;
      end
      if (w) begin mmem[c][nsp] = data; mval[c][nsp] = 1; end
      msp[c] = nsp;
    end
    sb.push_back(peek(tag, c, orold));
    @(posedge clk); #1;
    compare_top();
  endtask

  initial begin
    for (int c = 0; c < 4; c++) for (int i = 0; i < 16; i++) mval[c][i] = 0;
    model_reset();

    // reset state
    #1;
    chk("rst.depth", 32'(depth), 0);
    chk("rst.ovf", 32'(ovf), 0);
    chk("rst.unf", 32'(unf), 0);
    chk("rst.fault", 32'(fault), 0);
    if (G) chk("rst.rd", 32'(rd), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); resetq = 1'b1;

    // basic push / pop on ctx 0
    op("p1", 0, PUSH, 1, 18'h1, 0, 0);
    op("p2", 0, PUSH, 1, 18'h2, 0, 0);
    op("p3", 0, PUSH, 1, 18'h3, 0, 0);
    chk("push3.rd", 32'(rd), 32'h3);
    chk("push3.depth", 32'(depth), G ? 3 : 0);
    op("pop", 0, POP, 0, '0, 0, 0);
    chk("pop.rd", 32'(rd), 32'h2);
    chk("pop.depth", 32'(depth), G ? 2 : 0);

    // independent contexts
    op("c1", 1, PUSH, 1, 18'hAA, 0, 0);
    op("c2", 2, PUSH, 1, 18'h55, 0, 0);
    op("sel1", 1, NONE, 0, '0, 0, 0);
    chk("ctx1.rd", 32'(rd), 32'hAA);
    chk("ctx1.depth", 32'(depth), G ? 1 : 0);
    op("sel0", 0, NONE, 0, '0, 0, 0);
    chk("ctx0.rd", 32'(rd), 32'h2);
    @(negedge clk); ctx = 2'd2; #1;
    chk("ctx2.comb_rd", 32'(rd), 32'h55);

    // overflow on ctx 3: 17 pushes, oldest cell overwritten
    for (int v = 0; v <= 16; v++) op("ovfp", 3, PUSH, 1, 18'(v), 0, 0);
    chk("ovf.flag", 32'(ovf), G ? 1 : 0);
    chk("ovf.depth", 32'(depth), G ? 16 : 0);
    chk("ovf.rd", 32'(rd), 16);
    op("ovfn", 3, NONE, 0, '0, 0, 0);
    chk("ovf.fault", 32'(fault), G ? 1 : 0);
    for (int i = 0; i < 16; i++) begin
      chk("drain.rd", 32'(rd), 32'(16 - i));
      op("drain", 3, POP, 0, '0, 0, 0);
    end

    // underflow and clr_err on ctx 0
    op("u1", 0, POP, 0, '0, 0, 0);
    op("u2", 0, POP, 0, '0, 0, 0);
    op("upop2", 0, POP2, 0, '0, 0, 0);
    chk("unf.flag", 32'(unf), G ? 1 : 0);
    chk("unf.depth", 32'(depth), 0);
    op("uclrpop", 0, POP, 0, '0, 0, 1);
    chk("unf.setwins", 32'(unf), G ? 1 : 0);
    op("uclr", 0, NONE, 0, '0, 0, 1);
    chk("unf.cleared", 32'(unf), 0);

    // hold
    op("h0", 1, PUSH, 1, 18'h9, 0, 0);
    op("hold", 1, PUSH, 1, 18'h7, 1, 0);
    chk("hold.rd", 32'(rd), 32'h9);
    chk("hold.depth", 32'(depth), G ? 2 : 0);
    op("rel", 1, PUSH, 1, 18'h7, 0, 0);
    chk("rel.rd", 32'(rd), 32'h7);
    chk("rel.depth", 32'(depth), G ? 3 : 0);

    // random mix across contexts
    for (int i = 0; i < 300; i++)
      op("rnd", int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
         18'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));

    // reset mid-operation
    @(negedge clk);
    ctx = 2'd0; delta = PUSH; we = 1'b1; wd = 18'h123; hold = 1'b0; clr_err = 1'b0;
    #2 resetq = 1'b0;
    #1;
    model_reset();
    chk("mrst.depth", 32'(depth), 0);
    chk("mrst.ovf", 32'(ovf), 0);
    chk("mrst.unf", 32'(unf), 0);
    chk("mrst.fault", 32'(fault), 0);
    if (G) chk("mrst.rd", 32'(rd), 0);
    @(posedge clk);
    @(negedge clk); resetq = 1'b1; we = 1'b0; delta = NONE;
    op("post", 0, PUSH, 0, '0, 0, 0);
    op("post2", 0, POP, 0, '0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
